// File: rtl/link_pkg.sv
// Shared constants and types for the 18-bit word link.
package link_pkg;

  localparam int unsigned WORD_W          = 18;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_WORD  = 3;
  localparam int unsigned WORDS_PER_FRAME = 97;
  // Unused low bits of the last byte of a word; they must arrive as zero.
  localparam int unsigned PAD_W           = BYTES_PER_WORD * BYTE_W - WORD_W;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_STOP = 2'd1,
    ERR_PAD  = 2'd2,
    ERR_GAP  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

  function automatic logic pad_clear(input logic [BYTE_W-1:0] b);
    return b[PAD_W-1:0] == {PAD_W{1'b0}};
  endfunction

endpackage

// File: rtl/rs485_byte_rx.sv
// RS-485 byte receiver: line synchroniser, bit timing and start/8 data/stop framing FSM.
module rs485_byte_rx
  import link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic              clk5MHz,
  input  logic              rst,
  input  logic              rs485_rx,
  input  logic              rx_en,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              stop_err,
  output logic              line_idle
);

  localparam int unsigned HALF        = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0]  BIT_RELOAD  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  HALF_RELOAD = (HALF == 0) ? 8'd0 : 8'(HALF - 1);

  logic              sync1_r;
  logic              sync2_r;
  rx_state_e         state_r;
  logic [7:0]        cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [BYTE_W-1:0] shift_r;
  logic              rx_s;
  logic              sample_s;

  assign rx_s     = sync2_r;
  assign sample_s = (cnt_r == 8'd0);

  // Stop-bit verdicts are combinational so the word stage can register them one cycle after the sample.
  assign rx_byte    = shift_r;
  assign byte_valid = rx_en && (state_r == RX_STOP) && sample_s && rx_s;
  assign stop_err   = rx_en && (state_r == RX_STOP) && sample_s && !rx_s;
  assign line_idle  = (state_r == RX_IDLE);

  // Two-flop synchroniser on the asynchronous line, idling high.
  always_ff @(posedge clk5MHz or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rs485_rx;
      sync2_r <= sync1_r;
    end
  end

  // Framing FSM; cnt_r counts down to the next sample point.
  always_ff @(posedge clk5MHz or posedge rst) begin
    if (rst) begin
      state_r   <= RX_IDLE;
      cnt_r     <= 8'd0;
      bit_cnt_r <= 3'd0;
      shift_r   <= {BYTE_W{1'b0}};
    end else if (!rx_en) begin
      state_r   <= RX_IDLE;
      cnt_r     <= 8'd0;
      bit_cnt_r <= 3'd0;
    end else begin
      case (state_r)
        RX_IDLE: begin
          if (!rx_s) begin
            bit_cnt_r <= 3'd0;
            // With no half-bit delay the detecting sample already confirms the start bit.
            if (HALF == 0) begin
              state_r <= RX_DATA;
              cnt_r   <= BIT_RELOAD;
            end else begin
              state_r <= RX_START;
              cnt_r   <= HALF_RELOAD;
            end
          end
        end
        RX_START: begin
          if (sample_s) begin
            if (rx_s) begin
              state_r <= RX_IDLE;
            end else begin
              state_r <= RX_DATA;
              cnt_r   <= BIT_RELOAD;
            end
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RX_DATA: begin
          if (sample_s) begin
            shift_r <= {shift_r[BYTE_W-2:0], rx_s};
            cnt_r   <= BIT_RELOAD;
            if (bit_cnt_r == 3'(BYTE_W - 1)) begin
              state_r <= RX_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RX_STOP: begin
          if (sample_s) begin
            state_r <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= RX_IDLE;
          end
        end
        default: begin
          state_r <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rs485_word_rx.sv
// Word receiver: assembles three bytes per 18-bit word, checks padding and inter-byte gaps,
// and counts words within a frame.
module rs485_word_rx #(
  parameter int unsigned CLKS_PER_BIT    = 1,
  parameter int unsigned WORDS_PER_FRAME = link_pkg::WORDS_PER_FRAME,
  parameter int unsigned GAP_TIMEOUT     = 64
) (
  input  logic                        clk5MHz,
  input  logic                        rst,
  input  logic                        rs485_rx,
  input  logic                        rx_en,
  output logic [link_pkg::WORD_W-1:0] data_out,
  output logic                        data_valid,
  output logic [6:0]                  word_idx,
  output logic                        frame_done,
  output logic                        err,
  output logic [1:0]                  err_code
);

  localparam logic [6:0]  LAST_IDX = 7'(WORDS_PER_FRAME - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);

  logic [link_pkg::BYTE_W-1:0] rx_byte_s;
  logic                        byte_valid_s;
  logic                        stop_err_s;
  logic                        line_idle_s;
  logic [link_pkg::BYTE_W-1:0] byte0_r;
  logic [link_pkg::BYTE_W-1:0] byte1_r;
  logic [1:0]                  byte_idx_r;
  logic [6:0]                  word_cnt_r;
  logic [15:0]                 gap_cnt_r;

  rs485_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .clk5MHz    (clk5MHz),
    .rst        (rst),
    .rs485_rx   (rs485_rx),
    .rx_en      (rx_en),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s),
    .stop_err   (stop_err_s),
    .line_idle  (line_idle_s)
  );

  // Byte assembly, word/frame counting, gap timer and error reporting.
  always_ff @(posedge clk5MHz or posedge rst) begin
    if (rst) begin
      data_out   <= {link_pkg::WORD_W{1'b0}};
      data_valid <= 1'b0;
      word_idx   <= 7'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= link_pkg::ERR_NONE;
      byte0_r    <= {link_pkg::BYTE_W{1'b0}};
      byte1_r    <= {link_pkg::BYTE_W{1'b0}};
      byte_idx_r <= 2'd0;
      word_cnt_r <= 7'd0;
      gap_cnt_r  <= 16'd0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (!rx_en) begin
        byte_idx_r <= 2'd0;
        word_cnt_r <= 7'd0;
        gap_cnt_r  <= 16'd0;
      end else if (stop_err_s) begin
        err        <= 1'b1;
        err_code   <= link_pkg::ERR_STOP;
        byte_idx_r <= 2'd0;
        gap_cnt_r  <= 16'd0;
      end else if (byte_valid_s) begin
        gap_cnt_r <= 16'd0;
        case (byte_idx_r)
          2'd0: begin
            byte0_r    <= rx_byte_s;
            byte_idx_r <= 2'd1;
          end
          2'd1: begin
            byte1_r    <= rx_byte_s;
            byte_idx_r <= 2'd2;
          end
          2'd2: begin
            byte_idx_r <= 2'd0;
            if (!link_pkg::pad_clear(rx_byte_s)) begin
              err      <= 1'b1;
              err_code <= link_pkg::ERR_PAD;
            end else begin
              data_out   <= {rx_byte_s[7:6], byte0_r, byte1_r};
              data_valid <= 1'b1;
              word_idx   <= word_cnt_r;
              if (word_cnt_r == LAST_IDX) begin
                frame_done <= 1'b1;
                word_cnt_r <= 7'd0;
              end else begin
                word_cnt_r <= word_cnt_r + 7'd1;
              end
            end
          end
          default: begin
            byte_idx_r <= 2'd0;
          end
        endcase
      end else if (line_idle_s && (byte_idx_r != 2'd0)) begin
        // A stalled word also restarts the frame, since its position is no longer trustworthy.
        if (gap_cnt_r == GAP_LAST) begin
          err        <= 1'b1;
          err_code   <= link_pkg::ERR_GAP;
          byte_idx_r <= 2'd0;
          word_cnt_r <= 7'd0;
          gap_cnt_r  <= 16'd0;
        end else begin
          gap_cnt_r <= gap_cnt_r + 16'd1;
        end
      end else begin
        gap_cnt_r <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_rs485_word_rx.sv
// Directed bench: an event-queue model of the word link checked every cycle against the DUT.
module tb_rs485_word_rx;

  localparam int WPF = 97;
  localparam int GAP = 64;

  logic clk5MHz = 1'b0;
  logic rst     = 1'b1;
  always #5 clk5MHz = ~clk5MHz;

  logic        rx1, en1, dv1, fd1, err1;
  logic [17:0] do1;
  logic [6:0]  wi1;
  logic [1:0]  ec1;
  logic        rx4, en4, dv4, fd4, err4;
  logic [17:0] do4;
  logic [6:0]  wi4;
  logic [1:0]  ec4;

  rs485_word_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk5MHz(clk5MHz), .rst(rst), .rs485_rx(rx1), .rx_en(en1),
    .data_out(do1), .data_valid(dv1), .word_idx(wi1), .frame_done(fd1),
    .err(err1), .err_code(ec1));

  rs485_word_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk5MHz(clk5MHz), .rst(rst), .rs485_rx(rx4), .rx_en(en4),
    .data_out(do4), .data_valid(dv4), .word_idx(wi4), .frame_done(fd4),
    .err(err4), .err_code(ec4));

  typedef struct {
    bit          is_err;
    logic [17:0] data;
    logic [6:0]  idx;
    bit          fd;
    logic [1:0]  code;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  m_bytes[2];
  int          m_nb = 0;
  int          m_wcnt = 0;
  logic [17:0] m_data = 18'd0;
  logic [6:0]  m_idx = 7'd0;
  logic [1:0]  m_code = 2'd0;
  int          fd_cnt = 0;
  int          fd_idx = -1;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_stop_cyc = 0;
  int          v4 = 0;
  int          e4 = 0;

  always @(posedge clk5MHz) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: what the link must report, per byte received.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    e.is_err = 1'b0; e.data = 18'd0; e.idx = 7'd0; e.fd = 1'b0; e.code = 2'd0;
    if (!stop_ok) begin
      e.is_err = 1'b1; e.code = 2'd1; exp_q.push_back(e); m_nb = 0;
    end else if (m_nb < 2) begin
      m_bytes[m_nb] = b; m_nb++;
    end else begin
      m_nb = 0;
      if ((b & 8'h3F) != 8'h00) begin
        e.is_err = 1'b1; e.code = 2'd2; exp_q.push_back(e);
      end else begin
        e.data = {b[7:6], m_bytes[0], m_bytes[1]};
        e.idx  = 7'(m_wcnt);
        e.fd   = (m_wcnt == WPF - 1);
        exp_q.push_back(e);
        m_wcnt = (m_wcnt + 1) % WPF;
      end
    end
  endtask

  task automatic model_clear();
    m_nb = 0; m_wcnt = 0;
  endtask

  task automatic bit1(input logic b);
    @(posedge clk5MHz); #1; rx1 = b;
  endtask

  task automatic send_byte1(input logic [7:0] b, input bit stop_ok);
    bit1(1'b0);
    for (int i = 7; i >= 0; i--) bit1(b[i]);
    bit1(stop_ok);
    last_stop_cyc = cyc;
    model_byte(b, stop_ok);
  endtask

  task automatic send_word1(input logic [17:0] w);
    send_byte1(w[15:8], 1'b1);
    send_byte1(w[7:0], 1'b1);
    send_byte1({w[17:16], 6'b000000}, 1'b1);
  endtask

  task automatic idle1(input int n);
    ev_t e;
    if (m_nb != 0 && n >= GAP) begin
      e.is_err = 1'b1; e.data = 18'd0; e.idx = 7'd0; e.fd = 1'b0; e.code = 2'd3;
      exp_q.push_back(e);
      model_clear();
    end
    repeat (n) bit1(1'b1);
  endtask

  task automatic bit4(input logic b);
    repeat (4) begin @(posedge clk5MHz); #1; rx4 = b; end
  endtask

  task automatic send_byte4(input logic [7:0] b);
    bit4(1'b0);
    for (int i = 7; i >= 0; i--) bit4(b[i]);
    bit4(1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk5MHz); n++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(posedge clk5MHz);
  endtask

  // Per-cycle compare of dut1 against the model's event queue and held values.
  always @(posedge clk5MHz) begin
    ev_t e;
    #2;
    if (!rst) begin
      if (dv1 || err1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, dv1, err1}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data_valid", dv1, !e.is_err);
          chk("err", err1, e.is_err);
          if (e.is_err) begin
            chk("err_code", ec1, e.code);
            chk("frame_done_on_err", fd1, 1'b0);
            m_code = e.code;
          end else begin
            chk("data_out", do1, e.data);
            chk("word_idx", wi1, e.idx);
            chk("frame_done", fd1, e.fd);
            chk("latency", cyc - last_stop_cyc, 3);
            m_data = e.data;
            m_idx  = e.idx;
            if (fd1) begin fd_cnt++; fd_idx = int'(wi1); end
          end
        end
      end else begin
        chk("frame_done_idle", fd1, 1'b0);
        chk("data_out_hold", do1, m_data);
        chk("word_idx_hold", wi1, m_idx);
        chk("err_code_hold", ec1, m_code);
      end
    end
  end

  always @(posedge clk5MHz) begin
    #2;
    if (!rst) begin
      if (dv4) v4++;
      if (err4) e4++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rx1 = 1'b1; en1 = 1'b1; rx4 = 1'b1; en4 = 1'b1;
    repeat (3) @(posedge clk5MHz);
    #1 rst = 1'b0;
    @(posedge clk5MHz); #2;
    chk("rst_data_out", do1, 18'd0);
    chk("rst_data_valid", dv1, 1'b0);
    chk("rst_word_idx", wi1, 7'd0);
    chk("rst_frame_done", fd1, 1'b0);
    chk("rst_err", err1, 1'b0);
    chk("rst_err_code", ec1, 2'd0);
    chk("rst_data_out4", do4, 18'd0);
    repeat (3) @(posedge clk5MHz);

    // Single word, back-to-back bytes A5 C3 80
    send_word1(18'h2A5C3);
    drain("first_word");
    chk("first_data", do1, 18'h2A5C3);
    chk("first_idx", wi1, 7'd0);
    chk("first_err_code", ec1, 2'd0);

    // Clear counters via rx_en, then one full frame of value = index
    @(posedge clk5MHz); #1 en1 = 1'b0;
    model_clear();
    repeat (4) @(posedge clk5MHz);
    #1 en1 = 1'b1;
    repeat (2) @(posedge clk5MHz);
    for (int i = 0; i < WPF; i++) send_word1(18'(i));
    drain("frame");
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_idx", fd_idx, 96);
    chk("frame_last_data", do1, 18'd96);
    send_word1(18'h3FFFF);
    drain("wrap");
    chk("wrap_idx", wi1, 7'd0);
    chk("wrap_fd_count", fd_cnt, 1);

    for (int i = 1; i <= 4; i++) send_word1(18'(i + 200));
    drain("words_1_4");

    // Stop error on byte1 of word 5, then resend
    send_byte1(8'h12, 1'b1);
    send_byte1(8'h34, 1'b0);
    idle1(4);
    drain("stop_err");
    chk("stop_err_code", ec1, 2'd1);
    chk("stop_err_idx_held", wi1, 7'd4);
    send_word1(18'h12345);
    drain("resend");
    chk("resend_idx", wi1, 7'd5);
    chk("resend_data", do1, 18'h12345);

    // Pad error
    send_byte1(8'hA5, 1'b1);
    send_byte1(8'hC3, 1'b1);
    send_byte1(8'h81, 1'b1);
    idle1(2);
    drain("pad_err");
    chk("pad_err_code", ec1, 2'd2);
    chk("pad_data_held", do1, 18'h12345);

    // Gap just under the timeout is tolerated
    send_byte1(8'hA5, 1'b1);
    send_byte1(8'hC3, 1'b1);
    idle1(GAP - 4);
    send_byte1(8'h80, 1'b1);
    drain("gap_short");
    chk("gap_short_data", do1, 18'h2A5C3);
    chk("gap_short_idx", wi1, 7'd6);

    // Gap timeout clears the word counter
    send_byte1(8'hA5, 1'b1);
    send_byte1(8'hC3, 1'b1);
    idle1(GAP + 6);
    drain("gap_long");
    chk("gap_err_code", ec1, 2'd3);
    send_word1(18'h00001);
    drain("after_gap");
    chk("after_gap_idx", wi1, 7'd0);

    // rx_en dropped mid-byte
    send_byte1(8'hA5, 1'b1);
    bit1(1'b0); bit1(1'b1); bit1(1'b0); bit1(1'b1);
    @(posedge clk5MHz); #1 en1 = 1'b0; rx1 = 1'b1;
    model_clear();
    repeat (8) @(posedge clk5MHz);
    #1 en1 = 1'b1;
    repeat (4) @(posedge clk5MHz);
    send_word1(18'h3C3C3);
    drain("en_drop");
    chk("en_drop_idx", wi1, 7'd0);
    chk("en_drop_data", do1, 18'h3C3C3);
    chk("en_drop_err_code", ec1, 2'd3);

    // CLKS_PER_BIT = 4: one-cycle glitch, then a real word
    @(posedge clk5MHz); #1 rx4 = 1'b0;
    @(posedge clk5MHz); #1 rx4 = 1'b1;
    repeat (40) @(posedge clk5MHz);
    chk("glitch_valid4", v4, 0);
    chk("glitch_err4", e4, 0);
    send_byte4(8'hF0);
    send_byte4(8'hF0);
    send_byte4(8'h40);
    repeat (20) @(posedge clk5MHz);
    chk("cpb4_valid_count", v4, 1);
    chk("cpb4_data", do4, 18'h1F0F0);
    chk("cpb4_idx", wi4, 7'd0);
    chk("cpb4_err_count", e4, 0);
    chk("cpb4_err_code", ec4, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
